// File: rtl/latch_drain_pkg.sv
// Shared definitions for the latch cores: drain FSM encodings and a constant clog2 helper.
package latch_drain_pkg;

  typedef enum logic [0:0] {
    S_IDLE    = 1'b0,
    S_PRESENT = 1'b1
  } drain_state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/latch_drain_if.sv
// Valid/ready stream carrying one drained event index per beat.
interface latch_drain_if
  import latch_drain_pkg::*;
#(
  parameter int WIDTH = 32
);
  localparam int IDX_W = clog2(WIDTH);

  logic             m_valid;
  logic             m_ready;
  logic [IDX_W-1:0] m_index;
  logic             m_overrun;

  modport master (output m_valid, m_index, m_overrun, input m_ready);
  modport slave  (input m_valid, m_index, m_overrun, output m_ready);
endinterface

// File: rtl/latch_drain_rr_priority_enc.sv
// Round-robin priority encoder: lowest requesting index at or above ptr, wrapping past WIDTH-1.
module rr_priority_enc
  import latch_drain_pkg::*;
#(
  parameter int WIDTH = 32,
  localparam int IDX_W = clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_any
);

  localparam logic [IDX_W:0] W_L = (IDX_W+1)'(WIDTH);

  logic [2*WIDTH-1:0] dbl;
  logic [2*WIDTH-1:0] masked;
  logic [IDX_W:0]     first;

  // The upper copy of req supplies the wrapped-around candidates below ptr.
  always_comb begin
    dbl    = {req, req};
    masked = dbl & ~(((2*WIDTH)'(1) << ptr) - (2*WIDTH)'(1));
    first  = '0;
    for (int i = 2*WIDTH-1; i >= 0; i--) begin
      if (masked[i]) first = (IDX_W+1)'(i);
    end
    gnt_idx = IDX_W'((first >= W_L) ? (first - W_L) : first);
    gnt_any = |req;
  end

endmodule

// File: rtl/latch_drain.sv
// Sticky event latch reader: captures event pulses as pending flags and drains them
// one index per beat over a valid/ready stream, clearing each flag on acceptance.
module latch_drain
  import latch_drain_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [WIDTH-1:0]  din,
  input  logic [WIDTH-1:0]  clear,
  input  logic              enable,
  output logic [WIDTH-1:0]  pending,
  output logic [CNT_W-1:0]  drained,
  latch_drain_if.master     m
);

  localparam int IDX_W = clog2(WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  drain_state_t     state;
  logic [WIDTH-1:0] ovr;
  logic [WIDTH-1:0] ackmask;
  logic [WIDTH-1:0] pend_nxt;
  logic [WIDTH-1:0] ovr_nxt;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_any;
  logic             ack;

  rr_priority_enc #(.WIDTH(WIDTH)) u_enc (
    .req     (pending),
    .ptr     (rr_ptr),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  // A fresh pulse always wins, so a bit re-firing in its ack cycle is reported again;
  // such a re-fire is a new event, not an overrun.
  always_comb begin
    ack      = m.m_valid & m.m_ready;
    ackmask  = ack ? (WIDTH'(1) << m.m_index) : '0;
    pend_nxt = (pending & ~clear & ~ackmask) | din;
    ovr_nxt  = (ovr & ~clear & ~ackmask) | (din & pending & ~ackmask);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pending <= '0;
      ovr     <= '0;
    end else begin
      pending <= pend_nxt;
      ovr     <= ovr_nxt;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= S_IDLE;
      m.m_valid   <= 1'b0;
      m.m_index   <= '0;
      m.m_overrun <= 1'b0;
      drained     <= '0;
      rr_ptr      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (enable && gnt_any) begin
            m.m_index   <= gnt_idx;
            m.m_overrun <= ovr[gnt_idx];
            m.m_valid   <= 1'b1;
            state       <= S_PRESENT;
          end
        end
        S_PRESENT: begin
          if (m.m_ready) begin
            m.m_valid <= 1'b0;
            drained   <= drained + CNT_W'(1);
            rr_ptr    <= (m.m_index == LAST_IDX) ? '0 : m.m_index + IDX_W'(1);
            state     <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_latch_drain.sv
// Directed bench for latch_drain with a cycle-level reference model and beat log.
module tb_latch_drain;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] din = '0;
  logic [31:0] clear = '0;
  logic        enable = 1'b1;
  logic        ready = 1'b1;
  logic [31:0] pending;
  logic [15:0] drained;

  int total = 0;
  int bad = 0;
  int beats[$];

  // reference model state
  logic [31:0] mpend, movr;
  logic [15:0] mcnt;
  bit          mvalid, mout_ovr;
  int          midx, mptr;

  latch_drain_if #(.WIDTH(32)) bus ();
  assign bus.m_ready = ready;

  latch_drain #(.WIDTH(32), .CNT_W(16)) dut (
    .clk     (clk),
    .resetn  (resetn),
    .din     (din),
    .clear   (clear),
    .enable  (enable),
    .pending (pending),
    .drained (drained),
    .m       (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mpend = '0; movr = '0; mcnt = '0;
    mvalid = 0; mout_ovr = 0; midx = 0; mptr = 0;
  endtask

  task automatic model_step();
    logic [31:0] np, no;
    bit acked, found;
    bit accepted;
    accepted = mvalid && ready;
    for (int i = 0; i < 32; i++) begin
      acked = accepted && (midx == i);
      if (din[i]) begin
        np[i] = 1'b1;
        no[i] = (mpend[i] && !acked) || (movr[i] && !clear[i] && !acked);
      end else begin
        np[i] = mpend[i] && !clear[i] && !acked;
        no[i] = movr[i] && !clear[i] && !acked;
      end
    end
    if (accepted) begin
      mcnt   = mcnt + 16'd1;
      mptr   = (midx + 1) % 32;
      mvalid = 0;
    end else if (!mvalid && enable && mpend != 0) begin
      found = 0;
      for (int o = 0; o < 32; o++) begin
        int k;
        k = (mptr + o) % 32;
        if (!found && mpend[k]) begin
          found = 1; midx = k; mout_ovr = movr[k]; mvalid = 1;
        end
      end
    end
    mpend = np;
    movr  = no;
  endtask

  // Every-cycle comparison against the model, sampled on the falling edge.
  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      if (!resetn) model_reset();
      chk("pending", pending, mpend);
      chk("m_valid", 32'(bus.m_valid), 32'(mvalid));
      if (mvalid) begin
        chk("m_index", 32'(bus.m_index), 32'(midx));
        chk("m_overrun", 32'(bus.m_overrun), 32'(mout_ovr));
      end
      chk("drained", 32'(drained), 32'(mcnt));
      if (resetn) begin
        if (bus.m_valid && ready) beats.push_back(int'(bus.m_overrun) * 256 + int'(bus.m_index));
        model_step();
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    repeat (n) tick();
  endtask

  task automatic pulse(logic [31:0] d);
    din = d;
    tick();
    din = '0;
  endtask

  task automatic wait_valid(string name);
    int n;
    n = 0;
    while (!bus.m_valid && n < 40) begin
      tick();
      n++;
    end
    total++;
    if (!bus.m_valid) begin
      bad++;
      $display("FAIL %s: m_valid timeout got=0 want=1", name);
    end
  endtask

  task automatic chk_beats(string name, int n, int e0, int e1, int e2);
    int e[3];
    e[0] = e0; e[1] = e1; e[2] = e2;
    chk({name, "_count"}, 32'(beats.size()), 32'(n));
    for (int i = 0; i < n && i < beats.size(); i++)
      chk({name, "_beat"}, 32'(beats[i]), 32'(e[i]));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset
    idle(2);
    resetn = 1'b1;
    tick();
    chk("rst_pending", pending, 32'h0);
    chk("rst_valid", 32'(bus.m_valid), 32'h0);
    chk("rst_drained", 32'(drained), 32'h0);

    // single pulse, latency pinned
    beats.delete();
    din = 32'h10;
    tick();
    din = '0;
    chk("lat_pending", pending, 32'h10);
    chk("lat_valid0", 32'(bus.m_valid), 32'h0);
    tick();
    chk("lat_valid1", 32'(bus.m_valid), 32'h1);
    chk("lat_index", 32'(bus.m_index), 32'd4);
    chk("lat_ovr", 32'(bus.m_overrun), 32'h0);
    tick();
    chk("single_pending", pending, 32'h0);
    chk("single_drained", 32'(drained), 32'd1);
    chk_beats("single", 1, 4, 0, 0);

    // round-robin from a fresh pointer, including wrap 31 -> 0
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    tick();
    beats.delete();
    pulse(32'h8000_0003);
    idle(10);
    chk_beats("rr3", 3, 0, 1, 31);
    chk("rr3_drained", 32'(drained), 32'd3);
    beats.delete();
    pulse(32'h3);
    idle(8);
    chk_beats("rr2", 2, 0, 1, 0);
    chk("rr2_drained", 32'(drained), 32'd5);

    // back-pressure with re-fire during presentation
    ready = 1'b0;
    beats.delete();
    pulse(32'h4);
    wait_valid("bp");
    idle(4);
    pulse(32'h4);
    idle(5);
    chk("bp_valid", 32'(bus.m_valid), 32'h1);
    chk("bp_index", 32'(bus.m_index), 32'd2);
    chk("bp_ovr", 32'(bus.m_overrun), 32'h0);
    ready = 1'b1;
    idle(6);
    chk_beats("bp", 1, 2, 0, 0);
    chk("bp_pending", pending, 32'h0);

    // re-fire before the beat starts reports overrun
    enable = 1'b0;
    beats.delete();
    din = 32'h4;
    tick();
    tick();
    din = '0;
    enable = 1'b1;
    idle(6);
    chk_beats("ovr", 1, 256 + 2, 0, 0);
    chk("ovr_pending", pending, 32'h0);

    // re-fire in the ack cycle of the same index
    ready = 1'b0;
    beats.delete();
    pulse(32'h20);
    wait_valid("coll");
    ready = 1'b1;
    din = 32'h20;
    tick();
    din = '0;
    chk("coll_pending", pending, 32'h20);
    idle(6);
    chk_beats("coll", 2, 5, 5, 0);
    chk("coll_pending_end", pending, 32'h0);

    // enable hold-off and software clear
    enable = 1'b0;
    beats.delete();
    pulse(32'hF0);
    idle(4);
    chk("en_pending", pending, 32'hF0);
    chk("en_valid", 32'(bus.m_valid), 32'h0);
    clear = 32'h30;
    tick();
    clear = '0;
    chk("clr_pending", pending, 32'hC0);
    enable = 1'b1;
    idle(8);
    chk_beats("en", 2, 6, 7, 0);

    // clear of presented bit and enable drop mid-beat do not retract it
    ready = 1'b0;
    beats.delete();
    pulse(32'h300);
    wait_valid("cp");
    clear = 32'h100;
    tick();
    clear = '0;
    enable = 1'b0;
    idle(3);
    chk("cp_valid", 32'(bus.m_valid), 32'h1);
    chk("cp_index", 32'(bus.m_index), 32'd8);
    chk("cp_pending", pending, 32'h200);
    ready = 1'b1;
    idle(6);
    chk_beats("cp", 1, 8, 0, 0);
    chk("cp_idle_valid", 32'(bus.m_valid), 32'h0);

    // asynchronous reset while a beat is held
    ready = 1'b0;
    enable = 1'b1;
    wait_valid("ar");
    chk("ar_valid_before", 32'(bus.m_valid), 32'h1);
    #2;
    resetn = 1'b0;
    #1;
    chk("ar_valid", 32'(bus.m_valid), 32'h0);
    chk("ar_pending", pending, 32'h0);
    chk("ar_drained", 32'(drained), 32'h0);
    tick();
    resetn = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
